// File: rtl/dds_wave_gen_if.sv
// ---------------------------------------------------------------------------
// dds_wave_gen_if
// Purpose : bundles the channel-configuration write port and the valid/ready
//           sample stream of dds_wave_gen.
// Signals :
//   cfg_we     config write strobe            (host -> generator)
//   cfg_ch     channel index for the write    (host -> generator)
//   cfg_ftw    frequency tuning word          (host -> generator)
//   cfg_mode   waveform 0 saw/1 tri/2 sq/3 sin (host -> generator)
//   dout       unsigned offset-binary sample  (generator -> sink)
//   dout_ch    channel of dout                (generator -> sink)
//   dout_last  last channel of the frame      (generator -> sink)
//   dout_valid sample valid                   (generator -> sink)
//   dout_ready downstream accept              (sink -> generator)
// Modports: master = generator side, slave = host/sink side.
// ---------------------------------------------------------------------------
interface dds_wave_gen_if #(
    parameter int DATA_W  = 10,
    parameter int PHASE_W = 24
);
    logic               cfg_we;
    logic [3:0]         cfg_ch;
    logic [PHASE_W-1:0] cfg_ftw;
    logic [1:0]         cfg_mode;

    logic [DATA_W-1:0]  dout;
    logic [3:0]         dout_ch;
    logic               dout_last;
    logic               dout_valid;
    logic               dout_ready;

    modport master (
        input  cfg_we, cfg_ch, cfg_ftw, cfg_mode, dout_ready,
        output dout, dout_ch, dout_last, dout_valid
    );

    modport slave (
        output cfg_we, cfg_ch, cfg_ftw, cfg_mode, dout_ready,
        input  dout, dout_ch, dout_last, dout_valid
    );
endinterface

// File: rtl/dds_wave_gen.sv
// ---------------------------------------------------------------------------
// dds_wave_gen
// Purpose : multi-channel DDS test-signal source. Each channel owns a phase
//           accumulator, tuning word and waveform mode. Every RATE_DIV
//           enabled clocks a sample tick snapshots all channels and the
//           frame is emitted round-robin on one valid/ready stream.
// Ports   :
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   en       divider run enable (divider holds while low)
//   sync     clears accumulators, divider and overrun
//   bus      dds_wave_gen_if.master: config write port + sample stream
//   overrun  sticky flag: a tick arrived while a frame was still emitting
// Options : define DDS_DITHER_EN to add a 16-bit Galois LFSR (taps 0xB400,
//           seed 0xACE1) whose low 2 bits dither the phase index per load.
// ---------------------------------------------------------------------------
module dds_wave_gen #(
    parameter int DATA_W   = 10,
    parameter int PHASE_W  = 24,
    parameter int NCH      = 2,
    parameter int RATE_DIV = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           sync,
    dds_wave_gen_if.master bus,
    output logic           overrun
);

    localparam int CNT_W = $clog2(RATE_DIV);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int QW    = 2 * (DATA_W - 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(RATE_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCH - 1);
    localparam logic [DATA_W-1:0] HALF     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [QW-1:0]     H_MAX    = QW'(HALF - 1'b1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    // Divider
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    // Per-channel state. Only the top DATA_W phase bits ever reach the
    // waveform mapper, so the snapshot keeps just those.
    logic [PHASE_W-1:0] r_acc  [NCH];
    logic [PHASE_W-1:0] r_ftw  [NCH];
    logic [1:0]         r_mode [NCH];
    logic [DATA_W-1:0]  r_snap [NCH];

    // Emit FSM and output register
    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_dout;
    logic [3:0]        r_dout_ch;
    logic              r_dout_last;
    logic              r_dout_valid;
    logic              r_overrun;
    logic              w_load;

    // Waveform mapper
    logic [DATA_W-1:0] w_x;
    logic              w_m;
    logic [DATA_W-2:0] w_u;
    logic [DATA_W-1:0] w_nu;
    logic [QW-1:0]     w_q;
    logic [QW-1:0]     w_qs;
    logic [DATA_W-1:0] w_h;
    logic [DATA_W-1:0] w_wave;

    // ---------------------------------------------------------------- divider
    assign w_tick = en && !sync && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (sync) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------- channels
    // NOTE: channel state sits in flops rather than a RAM, so it is cleared
    // by reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_acc[k]  <= '0;
                r_ftw[k]  <= '0;
                r_mode[k] <= '0;
                r_snap[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                // NOTE: non-blocking assignment makes the snapshot capture the
                // pre-advance accumulator and the advance use the old FTW even
                // when a config write lands on the tick edge.
                if (sync) begin
                    r_acc[k] <= '0;
                end else if (w_tick) begin
                    r_snap[k] <= r_acc[k][PHASE_W-1 -: DATA_W];
                    r_acc[k]  <= r_acc[k] + r_ftw[k];
                end
                if (bus.cfg_we && (bus.cfg_ch == 4'(k))) begin
                    r_ftw[k]  <= bus.cfg_ftw;
                    r_mode[k] <= bus.cfg_mode;
                end
            end
        end
    end

    // ----------------------------------------------------------- dither LFSR
`ifdef DDS_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (sync) begin
            r_lfsr <= 16'hACE1;
        end else if (w_load) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
        end
    end

    assign w_x = r_snap[r_idx] + DATA_W'(r_lfsr[1:0]);
`else
    assign w_x = r_snap[r_idx];
`endif

    // ------------------------------------------------------- waveform mapper
    assign w_m  = w_x[DATA_W-1];
    assign w_u  = w_x[DATA_W-2:0];
    assign w_nu = HALF - {1'b0, w_u};
    // Parabola u*(N-u) peaks at N^2/4; scaling by 2^(DATA_W-3) maps the peak
    // to N, which is then clipped to N-1 so N+h stays within DATA_W bits.
    assign w_q  = QW'(w_u) * QW'(w_nu);
    assign w_qs = w_q >> (DATA_W - 3);
    assign w_h  = (w_qs > H_MAX) ? DATA_W'(H_MAX) : DATA_W'(w_qs);

    // NOTE: the default arm guarantees w_wave is assigned on every path, so
    // this stays pure combinational logic with no latch.
    always_comb begin
        case (r_mode[r_idx])
            2'd0:    w_wave = w_x;
            2'd1:    w_wave = w_m ? ~{w_u, 1'b0} : {w_u, 1'b0};
            2'd2:    w_wave = {DATA_W{w_m}};
            default: w_wave = w_m ? (HALF - w_h) : (HALF + w_h);
        endcase
    end

    // ------------------------------------------------- emit FSM and output
    assign w_load = (r_state == S_EMIT) && (!r_dout_valid || bus.dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_dout_last  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_dout       <= w_wave;
                r_dout_ch    <= 4'(r_idx);
                r_dout_last  <= (r_idx == IDX_LAST);
                r_dout_valid <= 1'b1;
                if (r_idx == IDX_LAST) begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            // A tick can only start a frame from IDLE, where no load happens,
            // so this never collides with the index update above.
            if (w_tick && (r_state == S_IDLE)) begin
                r_state <= S_EMIT;
                r_idx   <= '0;
            end

            if (sync) begin
                r_overrun <= 1'b0;
            end else if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_ch    = r_dout_ch;
    assign bus.dout_last  = r_dout_last;
    assign bus.dout_valid = r_dout_valid;
    assign overrun        = r_overrun;

endmodule
